// File: rtl/gopf_root_unpack.sv
// gopf_root_unpack: captures the packed Goppa root list on eval_done and streams valid roots oldest-first.
// Optional strict-ascending order check enabled by defining GOPF_ROOT_ORDER_CHECK_EN.
module gopf_root_unpack #(
    parameter int M        = 16,
    parameter int NUM_SLOT = 9,
    parameter int CNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  eval_done,
    input  logic [0:M*NUM_SLOT-1] list_dat,
    input  logic [CNT_W-1:0]      err_cnt,
    input  logic                  clr,
    output logic                  root_valid,
    input  logic                  root_ready,
    output logic [M-1:0]          root_dat,
    output logic                  root_last,
    output logic                  busy,
    output logic                  list_done,
    output logic                  cnt_ovf,
    output logic                  overrun,
    output logic                  order_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [M-1:0]     slot_q [NUM_SLOT];
    logic [CNT_W-1:0] n_q, k_q, n_in, idx;
    logic             capture, accept, too_many;

    always_comb begin
        too_many   = err_cnt > CNT_W'(NUM_SLOT);
        n_in       = too_many ? CNT_W'(NUM_SLOT) : err_cnt;
        capture    = (state == IDLE) && eval_done;
        root_valid = state == DRAIN;
        accept     = root_valid && root_ready;
        // slot 0 is the newest root, so the drain walks from slot n-1 down to slot 0
        idx        = n_q - k_q - CNT_W'(1);
        root_dat   = root_valid ? slot_q[idx] : '0;
        root_last  = root_valid && (k_q == n_q - CNT_W'(1));
        list_done  = state == DONE;
        busy       = state != IDLE;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int s = 0; s < NUM_SLOT; s++) slot_q[s] <= '0;
        end else if (clr) begin
            for (int s = 0; s < NUM_SLOT; s++) slot_q[s] <= '0;
        end else if (capture) begin
            for (int s = 0; s < NUM_SLOT; s++) slot_q[s] <= list_dat[s*M +: M];
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state   <= IDLE;
            n_q     <= '0;
            k_q     <= '0;
            cnt_ovf <= 1'b0;
            overrun <= 1'b0;
        end else if (clr) begin
            state   <= IDLE;
            n_q     <= '0;
            k_q     <= '0;
            cnt_ovf <= 1'b0;
            overrun <= 1'b0;
        end else begin
            // DONE counts as busy, so a list arriving on the DONE->IDLE edge is dropped too
            if (eval_done && busy)
                overrun <= 1'b1;
            case (state)
                IDLE: if (eval_done) begin
                    n_q     <= n_in;
                    k_q     <= '0;
                    cnt_ovf <= cnt_ovf | too_many;
                    state   <= (n_in == '0) ? DONE : DRAIN;
                end
                DRAIN: if (accept) begin
                    k_q <= k_q + CNT_W'(1);
                    if (root_last)
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GOPF_ROOT_ORDER_CHECK_EN
    logic [M-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            prev_q    <= '0;
            order_err <= 1'b0;
        end else if (clr) begin
            prev_q    <= '0;
            order_err <= 1'b0;
        end else if (capture) begin
            prev_q <= '0;
        end else if (accept) begin
            if (k_q != '0 && root_dat <= prev_q)
                order_err <= 1'b1;
            prev_q <= root_dat;
        end
    end
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_gopf_root_unpack.sv
// tb_gopf_root_unpack: table vectors, random lists and corner sequences checked against a list-level model.
module tb_gopf_root_unpack;
    localparam int M  = 16;
    localparam int NS = 9;
    localparam int CW = 4;
`ifdef GOPF_ROOT_ORDER_CHECK_EN
    localparam bit ORD = 1'b1;
`else
    localparam bit ORD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_b = 1'b0;
    logic            eval_done = 1'b0;
    logic [0:M*NS-1] list_dat = '0;
    logic [CW-1:0]   err_cnt = '0;
    logic            clr = 1'b0;
    logic            root_ready = 1'b0;
    logic            root_valid, root_last, busy, list_done, cnt_ovf, overrun, order_err;
    logic [M-1:0]    root_dat;

    int checks = 0;
    int errors = 0;
    bit ovf_exp, ovr_exp, ord_exp;

    typedef struct {
        int                   cnt;
        logic [NS-1:0][M-1:0] s;
        int                   mode;
        int                   exp_n;
        logic [M-1:0]         exp_first;
        bit                   exp_ovf;
    } vec_t;
    vec_t tbl[6];

    gopf_root_unpack #(.M(M), .NUM_SLOT(NS), .CNT_W(CW)) dut (
        .clk(clk), .rst_b(rst_b), .eval_done(eval_done), .list_dat(list_dat), .err_cnt(err_cnt),
        .clr(clr), .root_valid(root_valid), .root_ready(root_ready), .root_dat(root_dat),
        .root_last(root_last), .busy(busy), .list_done(list_done), .cnt_ovf(cnt_ovf),
        .overrun(overrun), .order_err(order_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    function automatic logic [NS-1:0][M-1:0] ramp(input logic [M-1:0] b, input logic [M-1:0] st);
        logic [NS-1:0][M-1:0] r;
        for (int i = 0; i < NS; i++) r[i] = b - 16'(i) * st;
        return r;
    endfunction

    task automatic pack(input logic [NS-1:0][M-1:0] s);
        for (int i = 0; i < NS; i++) list_dat[i*M +: M] = s[i];
    endtask

    task automatic flags_chk(input string tag);
        chk({tag, "_cnt_ovf"}, cnt_ovf, ovf_exp);
        chk({tag, "_overrun"}, overrun, ovr_exp);
        chk({tag, "_order_err"}, order_err, ORD ? ord_exp : 1'b0);
    endtask

    task automatic do_clr;
        clr = 1'b1;
        step;
        clr = 1'b0;
        ovf_exp = 0;
        ovr_exp = 0;
        ord_exp = 0;
    endtask

    // mode: 0 always ready, 1 toggling, 2 random; inj: loop cycle at which a second list is offered
    task automatic run_list(input int cnt, input logic [NS-1:0][M-1:0] s, input int mode, input int inj,
                            output int got_n, output logic [M-1:0] first);
        logic [M-1:0] q[$];
        int n, idx, cyc;
        bit done, prev_stall;
        logic [M-1:0] prev_dat;
        n = cnt > NS ? NS : cnt;
        for (int i = n - 1; i >= 0; i--) q.push_back(s[i]);
        if (cnt > NS) ovf_exp = 1;
        for (int i = 1; i < n; i++) if (q[i] <= q[i-1]) ord_exp = 1;
        pack(s);
        err_cnt = CW'(cnt);
        eval_done = 1'b1;
        step;
        eval_done = 1'b0;
        idx = 0; cyc = 0; done = 0; prev_stall = 0; first = '0; prev_dat = '0;
        while (!done && cyc < 200) begin
            root_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            if (cyc == inj) begin
                eval_done = 1'b1;
                list_dat = ~list_dat;
                err_cnt = 3;
                ovr_exp = 1;
            end
            smp;
            if (cyc == 0) begin
                chk("first_valid", root_valid, n > 0);
                chk("first_done", list_done, n == 0);
            end
            if (root_valid) begin
                if (idx >= n) chk("extra_root", 1, 0);
                else begin
                    if (idx == 0) first = root_dat;
                    chk("root_dat", root_dat, q[idx]);
                    chk("root_last", root_last, idx == n - 1);
                end
                if (prev_stall) chk("stall_stable", root_dat, prev_dat);
                prev_stall = !root_ready;
                prev_dat = root_dat;
                if (root_ready) idx++;
            end
            if (list_done) begin
                chk("done_after_all", idx, n);
                chk("done_no_valid", root_valid, 0);
                done = 1;
            end
            step;
            eval_done = 1'b0;
            cyc++;
        end
        if (!done) chk("drain_timeout", 0, 1);
        root_ready = 1'b0;
        smp;
        chk("done_single", list_done, 0);
        chk("idle_busy", busy, 0);
        flags_chk("list");
        got_n = idx;
        step;
    endtask

    initial begin
        int got;
        logic [M-1:0] f;
        logic [NS-1:0][M-1:0] rs;
        tbl[0] = '{3,  ramp(16'h0030, 16'h0010), 0, 3, 16'h0010, 1'b0};
        tbl[1] = '{9,  ramp(16'h0900, 16'h0100), 1, 9, 16'h0100, 1'b0};
        tbl[2] = '{0,  ramp(16'h1234, 16'h0001), 0, 0, 16'h0000, 1'b0};
        tbl[3] = '{2,  ramp(16'h0005, 16'h0005), 1, 2, 16'h0000, 1'b0};
        tbl[4] = '{1,  ramp(16'hBEEF, 16'h0001), 2, 1, 16'hBEEF, 1'b0};
        tbl[5] = '{12, ramp(16'h9000, 16'h1000), 0, 9, 16'h1000, 1'b1};

        #2;
        chk("rst_valid", root_valid, 0);
        chk("rst_dat", root_dat, 0);
        chk("rst_last", root_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", list_done, 0);
        flags_chk("rst");
        #1 rst_b = 1'b1;
        step;

        foreach (tbl[i]) begin
            run_list(tbl[i].cnt, tbl[i].s, tbl[i].mode, -1, got, f);
            chk("tbl_n", got, tbl[i].exp_n);
            if (tbl[i].exp_n > 0) chk("tbl_first", f, tbl[i].exp_first);
            chk("tbl_ovf", cnt_ovf, tbl[i].exp_ovf);
        end

        // clr and eval_done together: clr wins, nothing captured, sticky flags cleared
        pack(ramp(16'h0300, 16'h0100));
        err_cnt = 3;
        eval_done = 1'b1;
        do_clr;
        eval_done = 1'b0;
        smp;
        chk("clr_cap_busy", busy, 0);
        chk("clr_cap_valid", root_valid, 0);
        chk("clr_cap_done", list_done, 0);
        flags_chk("clr_cap");
        step;

        // second list during a drain is dropped
        run_list(4, ramp(16'h0400, 16'h0100), 0, 1, got, f);
        chk("ovr_n", got, 4);
        do_clr;
        smp;
        flags_chk("ovr_clr");
        step;

        // eval_done on the DONE->IDLE edge is ignored and flagged
        err_cnt = 0;
        eval_done = 1'b1;
        step;
        pack(ramp(16'h0200, 16'h0100));
        err_cnt = 2;
        smp;
        chk("done_edge_pulse", list_done, 1);
        step;
        eval_done = 1'b0;
        ovr_exp = 1;
        smp;
        chk("done_edge_busy", busy, 0);
        chk("done_edge_valid", root_valid, 0);
        flags_chk("done_edge");
        step;
        do_clr;

        for (int r = 0; r < 15; r++) begin
            for (int i = 0; i < NS; i++) rs[i] = 16'($urandom);
            run_list($urandom_range(0, 12), rs, 2, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1, got, f);
        end
        do_clr;

        // clr after 2 of 5 roots
        pack(ramp(16'h0500, 16'h0100));
        err_cnt = 5;
        eval_done = 1'b1;
        step;
        eval_done = 1'b0;
        root_ready = 1'b1;
        smp;
        chk("clr_mid_r0", root_dat, 16'h0100);
        step;
        smp;
        chk("clr_mid_r1", root_dat, 16'h0200);
        step;
        root_ready = 1'b0;
        do_clr;
        for (int c = 0; c < 4; c++) begin
            smp;
            chk("clr_mid_valid", root_valid, 0);
            chk("clr_mid_done", list_done, 0);
            chk("clr_mid_busy", busy, 0);
            step;
        end
        run_list(3, ramp(16'h0030, 16'h0010), 0, -1, got, f);
        chk("clr_recover_n", got, 3);

        // async reset after 2 of 9 roots of an overflowing list
        pack(ramp(16'h9000, 16'h1000));
        err_cnt = 12;
        eval_done = 1'b1;
        step;
        eval_done = 1'b0;
        root_ready = 1'b1;
        step;
        step;
        #1 rst_b = 1'b0;
        #1;
        chk("arst_valid", root_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_dat", root_dat, 0);
        chk("arst_ovf", cnt_ovf, 0);
        root_ready = 1'b0;
        @(negedge clk) rst_b = 1'b1;
        ovf_exp = 0; ovr_exp = 0; ord_exp = 0;
        for (int c = 0; c < 3; c++) begin
            smp;
            chk("arst_done", list_done, 0);
            chk("arst_valid2", root_valid, 0);
        end
        step;
        run_list(5, ramp(16'h0500, 16'h0100), 1, -1, got, f);
        chk("arst_recover_n", got, 5);

        // descending pair, then an ascending list keeps the sticky result
        rs = '0;
        rs[0] = 16'h0050;
        rs[1] = 16'h0100;
        run_list(2, rs, 0, -1, got, f);
        chk("order_first", f, 16'h0100);
        run_list(3, ramp(16'h0030, 16'h0010), 0, -1, got, f);
        do_clr;
        run_list(4, ramp(16'h0040, 16'h0010), 0, -1, got, f);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
